// File: rtl/trigger_capture.sv
// Write-side controller for the scope sample buffer: arms a level/slope trigger
// on the ADC stream, then writes one (optionally decimated) frame with addresses.
module trigger_capture #(
  parameter int DATA_W       = 12,
  parameter int DEPTH        = 640,
  parameter int ADDR_W       = 10,
  parameter int AUTO_TIMEOUT = 4096,
  parameter int HOLDOFF      = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [3:0]        decim,
  input  logic              auto_mode,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              period_flag,
  output logic              capturing,
  output logic              forced,
  output logic              overrun
);

  // state     | meaning
  // S_WAIT    | armed, looking for a threshold crossing or auto timeout
  // S_CAPTURE | writing kept samples into the display buffer
  // S_HOLDOFF | frame done, ignoring samples before re-arming
  localparam logic [1:0] S_WAIT    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  localparam int TO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);
  localparam logic [HO_W-1:0]   HO_LAST   = HO_W'(HOLDOFF - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q,       state_d;
  logic [DATA_W-1:0] prev_q,        prev_d;
  logic              prev_valid_q,  prev_valid_d;
  logic [TO_W-1:0]   to_cnt_q,      to_cnt_d;
  logic [3:0]        dec_cnt_q,     dec_cnt_d;
  logic [3:0]        decim_q,       decim_d;
  logic [ADDR_W-1:0] addr_q,        addr_d;
  logic [HO_W-1:0]   hold_cnt_q,    hold_cnt_d;
  logic              pend_q,        pend_d;
  logic              wr_en_q,       wr_en_d;
  logic [DATA_W-1:0] wr_data_q,     wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q,     wr_addr_d;
  logic              period_flag_q, period_flag_d;
  logic              forced_q,      forced_d;
  logic              overrun_q,     overrun_d;

  logic rise_hit;
  logic fall_hit;
  logic edge_hit;
  logic timeout_hit;
  logic keep;

  assign rise_hit    = prev_valid_q && (prev_q < trig_level) && (sample_in >= trig_level);
  assign fall_hit    = prev_valid_q && (prev_q > trig_level) && (sample_in <= trig_level);
  assign edge_hit    = trig_slope ? fall_hit : rise_hit;
  assign timeout_hit = auto_mode && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    to_cnt_d      = to_cnt_q;
    dec_cnt_d     = dec_cnt_q;
    decim_d       = decim_q;
    addr_d        = addr_q;
    hold_cnt_d    = hold_cnt_q;
    pend_d        = 1'b0;
    wr_en_d       = 1'b0;
    wr_data_d     = wr_data_q;
    wr_addr_d     = wr_addr_q;
    period_flag_d = pend_q;
    forced_d      = forced_q;
    overrun_d     = overrun_q;
    keep          = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (!auto_mode) begin
          to_cnt_d = '0;
        end
        if (sample_valid) begin
          prev_d       = sample_in;
          prev_valid_d = 1'b1;
          if (edge_hit || timeout_hit) begin
            // A real crossing wins over a coincident timeout.
            forced_d  = !edge_hit;
            overrun_d = 1'b0;
            decim_d   = decim;
            dec_cnt_d = '0;
            to_cnt_d  = '0;
            state_d   = S_CAPTURE;
            keep      = 1'b1;
          end else if (auto_mode) begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end

      S_CAPTURE: begin
        if (sample_valid) begin
          if (dec_cnt_q == decim_q) begin
            dec_cnt_d = '0;
            keep      = 1'b1;
          end else begin
            dec_cnt_d = dec_cnt_q + 1'b1;
          end
        end
      end

      S_HOLDOFF: begin
        if (HOLDOFF == 0) begin
          if (!pend_q) begin
            state_d      = S_WAIT;
            prev_valid_d = 1'b0;
            to_cnt_d     = '0;
          end
        end else if (sample_valid) begin
          if (hold_cnt_q == HO_LAST) begin
            hold_cnt_d   = '0;
            state_d      = S_WAIT;
            prev_valid_d = 1'b0;
            to_cnt_d     = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_WAIT;
      end
    endcase

    // A kept sample that meets a full buffer is lost and the column is retried.
    if (keep) begin
      if (fifo_full) begin
        overrun_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_data_d = sample_in;
        wr_addr_d = addr_q;
        if (addr_q == ADDR_LAST) begin
          addr_d     = '0;
          hold_cnt_d = '0;
          pend_d     = 1'b1;
          state_d    = S_HOLDOFF;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_WAIT;
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      to_cnt_q      <= '0;
      dec_cnt_q     <= '0;
      decim_q       <= '0;
      addr_q        <= '0;
      hold_cnt_q    <= '0;
      pend_q        <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      wr_addr_q     <= '0;
      period_flag_q <= 1'b0;
      forced_q      <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      to_cnt_q      <= to_cnt_d;
      dec_cnt_q     <= dec_cnt_d;
      decim_q       <= decim_d;
      addr_q        <= addr_d;
      hold_cnt_q    <= hold_cnt_d;
      pend_q        <= pend_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      wr_addr_q     <= wr_addr_d;
      period_flag_q <= period_flag_d;
      forced_q      <= forced_d;
      overrun_q     <= overrun_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign wr_addr     = wr_addr_q;
  assign period_flag = period_flag_q;
  assign capturing   = (state_q == S_CAPTURE);
  assign forced      = forced_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Bench for trigger_capture: per-sample behavioural model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_trigger_capture;

  localparam int DATA_W       = 12;
  localparam int DEPTH        = 8;
  localparam int ADDR_W       = 4;
  localparam int AUTO_TIMEOUT = 16;
  localparam int HOLDOFF      = 4;

  logic              clock;
  logic              reset;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic [3:0]        decim;
  logic              auto_mode;
  logic              fifo_full;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              period_flag;
  logic              capturing;
  logic              forced;
  logic              overrun;

  trigger_capture #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .AUTO_TIMEOUT(AUTO_TIMEOUT), .HOLDOFF(HOLDOFF)
  ) dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .trig_level(trig_level), .trig_slope(trig_slope), .decim(decim),
    .auto_mode(auto_mode), .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data),
    .wr_addr(wr_addr), .period_flag(period_flag), .capturing(capturing),
    .forced(forced), .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 = armed, 1 = capturing, 2 = ignoring samples after a frame.
  int m_phase = 0;
  bit m_have_prev = 0;
  int m_prev = 0;
  int m_wait_n = 0;
  int m_since = 0;
  int m_d = 0;
  int m_nwr = 0;
  int m_hold = 0;
  bit m_pf_next = 0;
  bit e_wr_en = 0;
  int e_wr_data = 0;
  int e_wr_addr = 0;
  bit e_pf = 0;
  bit e_forced = 0;
  bit e_overrun = 0;
  bit e_capt = 0;
  int cyc = 0;

  always @(posedge clock) begin
    int s;
    int lvl;
    bit hit;
    bit keep;
    cyc++;
    s    = int'(sample_in);
    lvl  = int'(trig_level);
    keep = 1'b0;
    if (!reset) begin
      m_phase = 0; m_have_prev = 0; m_wait_n = 0; m_since = 0; m_nwr = 0;
      m_hold = 0; m_pf_next = 0;
      e_wr_en = 0; e_wr_data = 0; e_wr_addr = 0; e_pf = 0; e_forced = 0; e_overrun = 0;
    end else begin
      e_pf = m_pf_next;
      m_pf_next = 0;
      e_wr_en = 0;
      if (!auto_mode) m_wait_n = 0;
      if (sample_valid) begin
        case (m_phase)
          0: begin
            hit = m_have_prev && (trig_slope ? (m_prev > lvl && s <= lvl)
                                             : (m_prev < lvl && s >= lvl));
            if (auto_mode) m_wait_n++;
            if (hit || (auto_mode && m_wait_n == AUTO_TIMEOUT)) begin
              e_forced = !hit; e_overrun = 0; m_d = int'(decim);
              m_since = 0; m_nwr = 0; m_wait_n = 0; m_phase = 1; keep = 1;
            end
            m_prev = s;
            m_have_prev = 1;
          end
          1: begin
            m_since++;
            keep = (m_since % (m_d + 1)) == 0;
          end
          default: begin
            m_hold++;
            if (m_hold == HOLDOFF) begin
              m_phase = 0; m_have_prev = 0; m_wait_n = 0;
            end
          end
        endcase
      end
      if (keep) begin
        if (fifo_full) e_overrun = 1;
        else begin
          e_wr_en = 1; e_wr_data = s; e_wr_addr = m_nwr; m_nwr++;
          if (m_nwr == DEPTH) begin
            m_phase = 2; m_hold = 0; m_pf_next = 1;
          end
        end
      end
    end
    e_capt = (m_phase == 1);
  end

  int log_data [64];
  int log_addr [64];
  int log_n = 0;
  int pf_n = 0;
  int pf_cyc = 0;
  int a7_cyc = 0;

  always @(negedge clock) begin
    if (chk_en) begin
      chk("wr_en", int'(wr_en), int'(e_wr_en));
      if (e_wr_en) begin
        chk("wr_data", int'(wr_data), e_wr_data);
        chk("wr_addr", int'(wr_addr), e_wr_addr);
      end
      chk("period_flag", int'(period_flag), int'(e_pf));
      chk("capturing", int'(capturing), int'(e_capt));
      chk("forced", int'(forced), int'(e_forced));
      chk("overrun", int'(overrun), int'(e_overrun));
    end
    if (wr_en === 1'b1) begin
      if (log_n < 64) begin
        log_data[log_n] = int'(wr_data);
        log_addr[log_n] = int'(wr_addr);
      end
      log_n++;
      if (wr_addr == ADDR_W'(DEPTH - 1)) a7_cyc = cyc;
    end
    if (period_flag === 1'b1) begin
      pf_n++;
      pf_cyc = cyc;
    end
  end

  task automatic send(input int v, input bit full);
    @(negedge clock);
    sample_valid = 1'b1;
    sample_in    = DATA_W'(v);
    fifo_full    = full;
    @(negedge clock);
    sample_valid = 1'b0;
    fifo_full    = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic clear_log();
    log_n = 0;
    pf_n  = 0;
  endtask

  task automatic check_log(input string nm, input int exp[8]);
    chk({nm, "_count"}, log_n, 8);
    for (int j = 0; j < 8; j++) begin
      chk({nm, "_data"}, log_data[j], exp[j]);
      chk({nm, "_addr"}, log_addr[j], j);
    end
  endtask

  initial begin
    int exp_rise[8]  = '{1200, 1240, 1280, 1320, 1360, 1400, 1440, 1480};
    int exp_fall[8]  = '{1200, 1160, 1120, 1080, 1040, 1000, 960, 920};
    int exp_decim[8] = '{1040, 1160, 1280, 1400, 1520, 1640, 1760, 1880};
    int exp_ovr[8]   = '{1200, 1240, 1320, 1360, 1400, 1440, 1480, 1520};

    reset = 1'b0; sample_valid = 1'b0; sample_in = '0; trig_level = '0;
    trig_slope = 1'b0; decim = 4'd0; auto_mode = 1'b0; fifo_full = 1'b0;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_capturing", int'(capturing), 0);
    chk("rst_period_flag", int'(period_flag), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Rising trigger at 1200 on a 40-step ramp.
    trig_level = 12'd1200;
    clear_log();
    for (int i = 0; i < 14; i++) send(1000 + 40 * i, 1'b0);
    check_log("rise", exp_rise);
    chk("rise_pflag_count", pf_n, 1);
    chk("rise_pflag_delay", pf_cyc - a7_cyc, 1);
    for (int i = 0; i < 3; i++) send(0, 1'b0);

    // Falling trigger: nothing on the way up, first write 1200 on the way down.
    trig_slope = 1'b1;
    clear_log();
    for (int i = 0; i < 13; i++) send(1000 + 40 * i, 1'b0);
    chk("fall_no_write_rising", log_n, 0);
    for (int k = 1; k <= 18; k++) send(1480 - 40 * k, 1'b0);
    check_log("fall", exp_fall);

    // Decimation by 3 with decim changed mid-frame.
    trig_slope = 1'b0;
    trig_level = 12'd1040;
    decim      = 4'd2;
    clear_log();
    for (int i = 0; i < 27; i++) begin
      if (i == 10) decim = 4'd0;
      send(1000 + 40 * i, 1'b0);
    end
    check_log("decim", exp_decim);

    // Auto trigger on the 16th flat sample, then nothing with auto off.
    trig_level = 12'd2000;
    auto_mode  = 1'b1;
    clear_log();
    for (int i = 0; i < 15; i++) send(500, 1'b0);
    chk("auto_before_timeout", log_n, 0);
    send(500, 1'b0);
    chk("auto_first_count", log_n, 1);
    chk("auto_first_data", log_data[0], 500);
    chk("auto_first_addr", log_addr[0], 0);
    chk("auto_forced", int'(forced), 1);
    for (int i = 0; i < 11; i++) send(500, 1'b0);
    chk("auto_frame_count", log_n, 8);
    auto_mode = 1'b0;
    clear_log();
    for (int i = 0; i < 20; i++) send(500, 1'b0);
    chk("noauto_no_write", log_n, 0);
    chk("noauto_forced_held", int'(forced), 1);

    // Buffer full on the third kept sample.
    trig_level = 12'd1200;
    clear_log();
    for (int i = 0; i < 18; i++) send(1000 + 40 * i, i == 7);
    check_log("ovr", exp_ovr);
    chk("ovr_sticky", int'(overrun), 1);
    chk("ovr_forced_cleared", int'(forced), 0);

    // Reset while the address-5 write is on the bus.
    clear_log();
    for (int i = 0; i < 10; i++) send(1000 + 40 * i, 1'b0);
    chk("rst_overrun_cleared_on_trig", int'(overrun), 0);
    @(negedge clock);
    sample_valid = 1'b1;
    sample_in    = 12'd1400;
    @(negedge clock);
    sample_valid = 1'b0;
    chk("rst_pre_addr", int'(wr_addr), 5);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_wr_en", int'(wr_en), 0);
    chk("rst_mid_wr_addr", int'(wr_addr), 0);
    chk("rst_mid_wr_data", int'(wr_data), 0);
    chk("rst_mid_capturing", int'(capturing), 0);
    chk("rst_mid_pflag", int'(period_flag), 0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst_no_pflag", pf_n, 0);
    clear_log();
    for (int i = 0; i < 14; i++) send(1000 + 40 * i, 1'b0);
    check_log("after_rst", exp_rise);
    for (int i = 0; i < 3; i++) send(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
Write-side controller for the oscilloscope sample buffer. It watches the ADC sample stream and arms a level/slope trigger. After a trigger it writes one screen's worth of samples, optionally decimated, into the display Fifo with addresses. When the frame is complete it pulses period_flag, so the VGA-side reader starts a new sweep.

Parameters:
DATA_W, 12, ADC sample width
DEPTH, 640, samples per captured frame (one per visible pixel column)
ADDR_W, 10, write address width; DEPTH <= 2**ADDR_W
AUTO_TIMEOUT, 4096, accepted samples in WAIT_TRIG before a forced trigger when auto_mode=1
HOLDOFF, 64, accepted samples ignored after a frame before re-arming

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-low; sampled on posedge clock
sample_valid  in  1  one-cycle strobe: sample_in is a new ADC sample
sample_in  in  DATA_W  ADC sample, unsigned
trig_level  in  DATA_W  trigger threshold, unsigned
trig_slope  in  1  0 = rising edge, 1 = falling edge
decim  in  4  keep 1 of every decim+1 samples after the trigger
auto_mode  in  1  1 = forced trigger on timeout
fifo_full  in  1  buffer cannot accept a write
wr_en  out  1  write strobe to buffer
wr_data  out  DATA_W  sample to write
wr_addr  out  ADDR_W  column address 0..DEPTH-1
period_flag  out  1  one-cycle pulse: frame complete
capturing  out  1  high in CAPTURE state
forced  out  1  last frame was auto-triggered; held until next trigger
overrun  out  1  sticky: a capture write was dropped due to fifo_full

Behaviour:
- Reset (reset==0 at posedge): state=WAIT_TRIG, all outputs 0, prev_valid=0, all counters 0. Reset mid-capture abandons the frame with no period_flag.
- An accepted sample is any cycle with sample_valid=1. Every action below happens only on accepted samples, except the period_flag pulse.
- prev register: holds the last accepted sample. prev_valid is set after the first accepted sample in WAIT_TRIG and cleared on entry to WAIT_TRIG.
- WAIT_TRIG:
  - Rising trigger: prev_valid && prev < trig_level && sample_in >= trig_level.
  - Falling trigger: prev_valid && prev > trig_level && sample_in <= trig_level.
  - Compare unsigned at full DATA_W.
  - On a trigger: the triggering sample is written at address 0, decim is latched, dec_cnt=0, forced=0, go to CAPTURE.
  - auto_mode=1: timeout counter increments per accepted sample. When it reaches AUTO_TIMEOUT-1 without a trigger, that sample is treated as a trigger and forced=1.
  - Counter clears on entry to WAIT_TRIG. With auto_mode=0 it holds at 0.
- CAPTURE:
  - dec_cnt counts accepted samples.
  - A sample is written when dec_cnt==latched decim, then dec_cnt=0. Changing decim mid-frame has no effect.
  - Write: wr_en=1 the cycle after sample_valid (latency 1, registered), wr_data=sample, wr_addr=current address. wr_en is deasserted on every other cycle.
  - If fifo_full=1 in the accept cycle: no write, address does not advance, overrun=1 (cleared only by reset or on trigger).
  - After the write at address DEPTH-1: period_flag=1 for exactly one cycle, the cycle after that wr_en. Then go to HOLDOFF and clear the address.
- HOLDOFF: count HOLDOFF accepted samples, then enter WAIT_TRIG. HOLDOFF=0 enters WAIT_TRIG on the cycle after period_flag.
- Trigger detection is edge-only. A level already past the threshold at arm time does not trigger until it re-crosses.
- Simultaneous trigger and timeout on the same sample: treat as a real trigger, forced=0.

Test Plan:
- DEPTH=8, decim=0, level=1200, rising; ramp 1000,1040,... one sample per 10 clocks -> trigger on 1200. wr_addr 0..7 carries 1200..1480 step 40. period_flag is one cycle, exactly 1 clock after the address-7 wr_en.
- Same ramp, falling, level=1200; ramp up to 1480 then down by 40 -> first write is 1200 on the way down. No write on the rising pass.
- decim=2, DEPTH=4, ramp step 40 from 1000, level 1040 -> writes 1040,1160,1280,1400 at addresses 0..3. Changing decim to 0 mid-frame leaves the result unchanged.
- auto_mode=1, AUTO_TIMEOUT=16, constant input 500, level 2000 -> 16th accepted sample written at address 0 with forced=1. With auto_mode=0, no wr_en ever.
- fifo_full high for the 3rd kept sample, DEPTH=8 -> that sample is skipped, the address holds and 8 writes still complete. overrun=1 until the next trigger.
- Pull reset low at address 5 -> next cycle all outputs 0 with no period_flag. After release, the first crossing writes address 0.
